// File: rtl/fetch_prefetch_unit_if.sv
// APB bus bundle used by the fetch front end to reach instruction memory.
interface apb_if #(
    parameter int XLEN = 32
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [XLEN-1:0] paddr;
    logic [XLEN-1:0] prdata;
    logic            pready;
    logic            pslverr;

    modport master (
        output psel, penable, pwrite, paddr,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: APB master filling a DEPTH-entry prefetch FIFO,
// drained by decode over valid/ready, with redirect flush and in-flight squash.
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    apb_if.master                      imem_apb,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [XLEN-1:0]            pc_o,
    output logic [XLEN-1:0]            inst_o,
    output logic                       err_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    // Handshake: an entry moves to decode on a cycle where valid_o && ready_i
    // and no redirect is present; head fields are stable until that happens.

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

    apb_state_t      state;
    apb_state_t      state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] paddr_q;
    logic            squash;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [LW-1:0]   count_next;
    logic            complete;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] buf_pc   [DEPTH];
    logic [XLEN-1:0] buf_inst [DEPTH];
    logic            buf_err  [DEPTH];

    always_comb begin
        complete   = (state == ACCESS) && imem_apb.pready;
        push       = complete && !squash && !redirect_i;
        pop        = valid_o && ready_i && !redirect_i;
        count_next = redirect_i ? '0 : (count + LW'(push) - LW'(pop));
        state_next = state;
        case (state)
            IDLE: begin
                // Only one fetch is ever in flight, so a free slot now is a reserved slot.
                if (redirect_i || (count < LW'(DEPTH))) state_next = SETUP;
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (complete) state_next = (count_next < LW'(DEPTH)) ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            paddr_q  <= RESET_PC;
            squash   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state == SETUP) paddr_q <= fetch_pc;

            if (redirect_i) fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            else if (push)  fetch_pc <= paddr_q + XLEN'(4);

            // A transfer already on the bus must finish; its data is dropped on return.
            if (redirect_i && ((state == SETUP) || ((state == ACCESS) && !imem_apb.pready)))
                squash <= 1'b1;
            else if (complete)
                squash <= 1'b0;

            if (redirect_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= paddr_q;
            buf_inst[wr_ptr] <= imem_apb.prdata;
            buf_err[wr_ptr]  <= imem_apb.pslverr;
        end
    end

    assign imem_apb.psel    = (state != IDLE);
    assign imem_apb.penable = (state == ACCESS);
    assign imem_apb.pwrite  = 1'b0;
    assign imem_apb.paddr   = (state == ACCESS) ? paddr_q : fetch_pc;

    assign valid_o = (count != '0);
    assign pc_o    = valid_o ? buf_pc[rd_ptr]   : '0;
    assign inst_o  = valid_o ? buf_inst[rd_ptr] : '0;
    assign err_o   = valid_o ? buf_err[rd_ptr]  : 1'b0;
    assign level_o = count;
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end. It runs an APB master on the instruction memory and fills a DEPTH-entry prefetch buffer of {pc, inst, err} entries.
- It presents one instruction per cycle to decode over a valid/ready handshake.
- It supports redirects (jump, or branch mispredict correction) that flush the buffer and squash any in-flight APB fetch.
- It replaces the single-entry fetch stage between imem and decode.

Parameters:
- XLEN, 32, address/data width of pc, inst and APB.
- DEPTH, 4, prefetch buffer entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset; synchronous, active-low.
- imem_apb  apb_if.master  -  instruction memory APB. Uses psel, penable, pwrite, paddr[XLEN-1:0], prdata[XLEN-1:0], pready, pslverr.
- redirect_i  input  1  flush buffer and restart fetch at redirect_pc_i.
- redirect_pc_i  input  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
- ready_i  input  1  decode accepts head entry.
- valid_o  output  1  head entry valid.
- pc_o  output  XLEN  pc of head entry.
- inst_o  output  XLEN  instruction word of head entry.
- err_o  output  1  pslverr seen on head entry's fetch.
- level_o  output  $clog2(DEPTH+1)  buffer occupancy.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - APB state=IDLE; psel=0, penable=0, pwrite=0, paddr=RESET_PC.
  - fetch_pc=RESET_PC; buffer empty; valid_o=0, level_o=0, squash flag=0.
  - pc_o/inst_o/err_o=0.
  - Reset mid-transfer drops psel in the following cycle; no entry is written.
- pwrite is constantly 0.
- APB FSM has three states, IDLE / SETUP / ACCESS:
  - IDLE -> SETUP when level_o < DEPTH and redirect_i=0. Reservation: a fetch is started only if an empty slot exists counting the in-flight fetch, so a push never overflows.
  - SETUP: psel=1, penable=0, paddr=fetch_pc. Always -> ACCESS.
  - ACCESS: psel=1, penable=1, paddr held. Stay while pready=0.
  - On pready=1 with squash=0: push {paddr, prdata, pslverr}; fetch_pc += 4, wrapping mod 2^XLEN.
  - Next state after a completed ACCESS is SETUP (back-to-back) if a slot remains after this push and any concurrent pop; otherwise IDLE.
  - Maximum throughput is one instruction per 2 cycles.
- Latency: with pready always 1 and ready_i=0 after reset release at edge 0:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - valid_o=1 with pc_o=RESET_PC in cycle 3.
- Output handshake:
  - valid_o = (level_o != 0); pc_o/inst_o/err_o show the head entry, or 0 when empty.
  - A pop occurs when valid_o && ready_i.
  - Outputs are stable while valid_o=1 and ready_i=0.
- Push and pop in the same cycle: level is unchanged and FIFO order is preserved. When level=0, a pushed entry is first visible the next cycle; there is no bypass.
- Redirect (redirect_i=1):
  - The buffer is emptied at the next edge (level_o=0, valid_o=0).
  - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - A pop in the same cycle is ignored.
  - If the FSM is in SETUP, or in ACCESS with pready=0, the APB transfer is completed per protocol (address held), squash is set, and the returned data is discarded. squash clears on that completion, and the FSM then goes to SETUP at the new fetch_pc.
  - If the FSM is in ACCESS with pready=1 in the redirect cycle, the data is discarded and the next state is SETUP at the new pc.
  - In IDLE, the next state is SETUP at the new pc.
  - Back-to-back redirects: the last one wins.
- pslverr does not stop fetch. The entry carries err_o=1 and inst_o=prdata as returned.
- The counter and pointers wrap modulo DEPTH; level_o ranges over 0..DEPTH.

Test Plan:
- Reset release, pready=1, ready_i=0 -> paddr sequence 0x0,0x4,0x8,0xC. Fetch stops with level_o=4 and psel=0. pc_o=0x0 stays stable.
- ready_i=1 continuously, pready=1 -> one pop every 2 cycles; pc_o increments by 4; level_o never exceeds 1 after warm-up.
- pready held 0 for 3 cycles in ACCESS of pc 0x8, redirect_i to 0x100 in the first wait cycle -> paddr stays 0x8 until pready. Data is discarded, next SETUP has paddr=0x100, and the first valid_o shows pc_o=0x100.
- Buffer full (level 4) and redirect_i to 0x203 with ready_i=1 the same cycle -> next cycle level_o=0, no pop counted. The next fetch is at 0x200.
- pslverr=1 on the fetch of 0x4 -> the entry with pc 0x4 has err_o=1, and the neighbouring entries have err_o=0. Fetch continues at 0x8.
- rst_n=0 asserted during ACCESS -> next cycle psel=0, penable=0, level_o=0. After release, the first paddr is RESET_PC.
